// File: rtl/ajc_8bit_alu_core_pkg.sv
// Shared types and constants for the 8-bit ALU core.
// Unit selects, op codes, flag positions and fixed constant values.
package ajc_8bit_alu_core_pkg;

    typedef enum logic [1:0] {
        UNIT_ARITH = 2'b00,
        UNIT_LOGIC = 2'b01,
        UNIT_SHIFT = 2'b10,
        UNIT_CONST = 2'b11
    } unit_e;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_ADDK = 2'b10,
        OP_SUBK = 2'b11
    } arith_op_e;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOT = 2'b11
    } logic_op_e;

    typedef enum logic [1:0] {
        OP_ZERO = 2'b00,
        OP_ONE  = 2'b01,
        OP_ONES = 2'b10,
        OP_MSB  = 2'b11
    } const_op_e;

    localparam int FLAG_C = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 0;

    localparam logic [7:0] K_ZERO = 8'h00;
    localparam logic [7:0] K_ONE  = 8'h01;
    localparam logic [7:0] K_ONES = 8'hFF;
    localparam logic [7:0] K_MSB  = 8'h80;

    function automatic logic [3:0] make_flags(
        input logic c,
        input logic n,
        input logic v,
        input logic z
    );
        logic [3:0] f;
        f = '0;
        f[FLAG_C] = c;
        f[FLAG_N] = n;
        f[FLAG_V] = v;
        f[FLAG_Z] = z;
        return f;
    endfunction

endpackage

// File: rtl/ajc_8bit_alu_core_addsub.sv
// 8-bit adder with B select/invert and carry-in.
// Subtraction is X + ~B + 1, so carry out means no borrow.
module ajc_8bit_addsub
    import ajc_8bit_alu_core_pkg::*;
(
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic [7:0] k,
    input  arith_op_e  op,
    output logic [7:0] r,
    output logic       c,
    output logic       v
);

    logic [7:0] b;
    logic       cin;
    logic [8:0] sum;

    always_comb begin
        b   = y;
        cin = 1'b0;
        unique case (op)
            OP_ADD:  begin b = y;  cin = 1'b0; end
            OP_SUB:  begin b = ~y; cin = 1'b1; end
            OP_ADDK: begin b = k;  cin = 1'b0; end
            OP_SUBK: begin b = ~k; cin = 1'b1; end
            default: begin b = y;  cin = 1'b0; end
        endcase
    end

    assign sum = {1'b0, x} + {1'b0, b} + {8'b0, cin};
    assign r   = sum[7:0];
    assign c   = sum[8];
    assign v   = (x[7] == b[7]) && (sum[7] != x[7]);

endmodule

// File: rtl/ajc_8bit_alu_core.sv
// Registered 8-bit ALU: arith, logic and constant units.
// Shift select is reserved here and yields all-zero result and flags.
module ajc_8bit_alu_core
    import ajc_8bit_alu_core_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] func_sel,
    input  logic [7:0] operand_x,
    input  logic [7:0] operand_y,
    input  logic [1:0] const_k,
    output logic [7:0] alu_result,
    output logic [3:0] alu_cnvz
);

    logic [7:0] k_ext;
    logic [7:0] arith_r;
    logic       arith_c;
    logic       arith_v;
    logic [7:0] logic_r;
    logic [7:0] const_r;
    logic [7:0] next_r;
    logic [3:0] next_f;

    assign k_ext = {6'b0, const_k};

    ajc_8bit_addsub u_addsub (
        .x  (operand_x),
        .y  (operand_y),
        .k  (k_ext),
        .op (arith_op_e'(func_sel[1:0])),
        .r  (arith_r),
        .c  (arith_c),
        .v  (arith_v)
    );

    always_comb begin
        logic_r = '0;
        unique case (logic_op_e'(func_sel[1:0]))
            OP_AND:  logic_r = operand_x & operand_y;
            OP_OR:   logic_r = operand_x | operand_y;
            OP_XOR:  logic_r = operand_x ^ operand_y;
            OP_NOT:  logic_r = ~operand_x;
            default: logic_r = '0;
        endcase
    end

    always_comb begin
        const_r = K_ZERO;
        unique case (const_op_e'(func_sel[1:0]))
            OP_ZERO: const_r = K_ZERO;
            OP_ONE:  const_r = K_ONE;
            OP_ONES: const_r = K_ONES;
            OP_MSB:  const_r = K_MSB;
            default: const_r = K_ZERO;
        endcase
    end

    always_comb begin
        next_r = '0;
        next_f = '0;
        unique case (unit_e'(func_sel[3:2]))
            UNIT_ARITH: begin
                next_r = arith_r;
                next_f = make_flags(arith_c, arith_r[7],
                                    arith_v, arith_r == 8'h00);
            end
            UNIT_LOGIC: begin
                next_r = logic_r;
                next_f = make_flags(1'b0, logic_r[7],
                                    1'b0, logic_r == 8'h00);
            end
            UNIT_CONST: begin
                next_r = const_r;
                next_f = make_flags(1'b0, const_r[7],
                                    1'b0, const_r == 8'h00);
            end
            // Reserved: Z intentionally left clear despite zero result
            UNIT_SHIFT: begin
                next_r = '0;
                next_f = '0;
            end
            default: begin
                next_r = '0;
                next_f = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_result <= '0;
            alu_cnvz   <= '0;
        end else if (en) begin
            alu_result <= next_r;
            alu_cnvz   <= next_f;
        end
    end

endmodule

// File: tb/tb_ajc_8bit_alu_core.sv
// Directed-vector bench for the registered 8-bit ALU core.
// Table of hand-computed vectors plus hold/reset sequences.
module tb_ajc_8bit_alu_core;

    logic       clk;
    logic       reset;
    logic       en;
    logic [3:0] func_sel;
    logic [7:0] operand_x;
    logic [7:0] operand_y;
    logic [1:0] const_k;
    logic [7:0] alu_result;
    logic [3:0] alu_cnvz;

    int checks;
    int errors;

    typedef struct {
        string      name;
        logic [3:0] f;
        logic [7:0] x;
        logic [7:0] y;
        logic [1:0] k;
        logic [7:0] r;
        logic [3:0] cnvz;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    ajc_8bit_alu_core dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .func_sel   (func_sel),
        .operand_x  (operand_x),
        .operand_y  (operand_y),
        .const_k    (const_k),
        .alu_result (alu_result),
        .alu_cnvz   (alu_cnvz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name,
                       input logic [7:0] got_r,
                       input logic [3:0] got_f,
                       input logic [7:0] exp_r,
                       input logic [3:0] exp_f);
        checks++;
        if (got_r !== exp_r || got_f !== exp_f) begin
            errors++;
            $display("FAIL %s: result=%h cnvz=%b, expected result=%h cnvz=%b",
                     name, got_r, got_f, exp_r, exp_f);
        end
    endtask

    task automatic drive(input logic [3:0] f, input logic [7:0] x,
                         input logic [7:0] y, input logic [1:0] k);
        func_sel  = f;
        operand_x = x;
        operand_y = y;
        const_k   = k;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        vecs[0]  = '{"add_ovf",   4'b0000, 8'h7F, 8'h01, 2'd0, 8'h80, 4'b0110};
        vecs[1]  = '{"sub_eq",    4'b0001, 8'h05, 8'h05, 2'd0, 8'h00, 4'b1001};
        vecs[2]  = '{"sub_brw",   4'b0001, 8'h00, 8'h01, 2'd0, 8'hFF, 4'b0100};
        vecs[3]  = '{"addk_wrap", 4'b0010, 8'hFF, 8'h00, 2'd2, 8'h01, 4'b1000};
        vecs[4]  = '{"and",       4'b0100, 8'hF0, 8'h3C, 2'd0, 8'h30, 4'b0000};
        vecs[5]  = '{"xor_zero",  4'b0110, 8'hAA, 8'hAA, 2'd0, 8'h00, 4'b0001};
        vecs[6]  = '{"const_ff",  4'b1110, 8'h12, 8'h34, 2'd1, 8'hFF, 4'b0100};
        vecs[7]  = '{"subk_ovf",  4'b0011, 8'h80, 8'h00, 2'd1, 8'h7F, 4'b1010};
        vecs[8]  = '{"or",        4'b0101, 8'h0F, 8'hF0, 2'd0, 8'hFF, 4'b0100};
        vecs[9]  = '{"not_zero",  4'b0111, 8'hFF, 8'h00, 2'd0, 8'h00, 4'b0001};
        vecs[10] = '{"const_00",  4'b1100, 8'hFF, 8'hFF, 2'd3, 8'h00, 4'b0001};
        vecs[11] = '{"const_01",  4'b1101, 8'h00, 8'h00, 2'd0, 8'h01, 4'b0000};
        vecs[12] = '{"const_80",  4'b1111, 8'h00, 8'h00, 2'd0, 8'h80, 4'b0100};
        vecs[13] = '{"add_carry", 4'b0000, 8'hFF, 8'h01, 2'd0, 8'h00, 4'b1001};
        vecs[14] = '{"add_negov", 4'b0000, 8'h80, 8'h80, 2'd0, 8'h00, 4'b1011};
        vecs[15] = '{"subk_k3",   4'b0011, 8'h10, 8'hAA, 2'd3, 8'h0D, 4'b1000};
        vecs[16] = '{"addk_k0",   4'b0010, 8'h00, 8'h55, 2'd0, 8'h00, 4'b0001};
        vecs[17] = '{"sub_nov",   4'b0001, 8'h80, 8'h01, 2'd0, 8'h7F, 4'b1010};

        reset = 1'b1;
        en    = 1'b0;
        drive(4'b0000, 8'h00, 8'h00, 2'd0);
        #1;
        chk("reset_init", alu_result, alu_cnvz, 8'h00, 4'b0000);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        en = 1'b1;
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].f, vecs[i].x, vecs[i].y, vecs[i].k);
            @(posedge clk);
            #1;
            chk(vecs[i].name, alu_result, alu_cnvz, vecs[i].r, vecs[i].cnvz);
        end

        // Hold: last vector left 0x7F / 1010 in the registers
        en = 1'b0;
        drive(4'b1110, 8'h00, 8'h00, 2'd3);
        @(posedge clk);
        drive(4'b0100, 8'h33, 8'h44, 2'd1);
        @(posedge clk);
        #1;
        chk("hold", alu_result, alu_cnvz, 8'h7F, 4'b1010);

        en = 1'b1;
        drive(4'b1110, 8'h00, 8'h00, 2'd0);
        @(posedge clk);
        #1;
        chk("load_ff", alu_result, alu_cnvz, 8'hFF, 4'b0100);

        #2;
        reset = 1'b1;
        #1;
        chk("reset_async", alu_result, alu_cnvz, 8'h00, 4'b0000);
        @(posedge clk);
        #1;
        chk("reset_held", alu_result, alu_cnvz, 8'h00, 4'b0000);

        reset = 1'b0;
        en    = 1'b0;
        drive(4'b0000, 8'h7F, 8'h01, 2'd0);
        @(posedge clk);
        #1;
        chk("post_rst_noen", alu_result, alu_cnvz, 8'h00, 4'b0000);
        en = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_load", alu_result, alu_cnvz, 8'h80, 4'b0110);

        for (int s = 0; s < 4; s++) begin
            drive({2'b10, 2'(s)}, 8'h5A, 8'hA5, 2'(s));
            @(posedge clk);
            #1;
            chk("reserved", alu_result, alu_cnvz, 8'h00, 4'b0000);
            drive(4'b1111, 8'h00, 8'h00, 2'd0);
            @(posedge clk);
            #1;
            chk("b2b_const80", alu_result, alu_cnvz, 8'h80, 4'b0100);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
